// File: rtl/vga_sync.sv
// VGA raster timing generator: pixel-rate toggle, x/y counters, raw sync decode and a
// pixel-rate output register that aligns sync and gated colour one pixel behind x/y.
module vga_sync #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rgb_in,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        pixel_tick,
  output logic        video_on,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic [2:0]  red,
  output logic [2:0]  green,
  output logic [1:0]  blue
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS      = 11'(H_DISPLAY);
  localparam logic [10:0] V_VIS      = 11'(V_DISPLAY);
  localparam logic [10:0] HS_FIRST   = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] HS_LAST    = 11'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [10:0] VS_FIRST   = 11'(V_DISPLAY + V_FRONT);
  localparam logic [10:0] VS_LAST    = 11'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic        toggle_q, toggle_d;
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic [7:0]  rgb_q, rgb_d;

  logic        hsync_raw;
  logic        vsync_raw;
  logic        visible;
  logic        h_wrap;

  assign visible   = (x_q < H_VIS) && (y_q < V_VIS);
  assign hsync_raw = ~((x_q >= HS_FIRST) && (x_q <= HS_LAST));
  assign vsync_raw = ~((y_q >= VS_FIRST) && (y_q <= VS_LAST));
  assign h_wrap    = (x_q == H_LAST);

  always_comb begin
    toggle_d = ~toggle_q;
    x_d      = x_q;
    y_d      = y_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    rgb_d    = rgb_q;
    // Phase B: counters advance and the output stage captures the pixel just finished.
    if (toggle_q) begin
      if (h_wrap) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 11'd1;
      end else begin
        x_d = x_q + 11'd1;
      end
      hsync_d = hsync_raw;
      vsync_d = vsync_raw;
      rgb_d   = visible ? rgb_in : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      toggle_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      rgb_q    <= '0;
    end else begin
      toggle_q <= toggle_d;
      x_q      <= x_d;
      y_q      <= y_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      rgb_q    <= rgb_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign pixel_tick  = toggle_q;
  assign video_on    = visible;
  assign frame_start = toggle_q && h_wrap && (y_q == V_LAST);
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign red         = rgb_q[7:5];
  assign green       = rgb_q[4:2];
  assign blue        = rgb_q[1:0];

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: a shrunk-timing instance checked every clk against an arithmetic raster
// model with random colour input, plus a default-timing instance checked over its first lines.
module tb_vga_sync;

  localparam int unsigned HD = 16, HF = 4, HS = 6, HB = 5;
  localparam int unsigned VD = 8,  VF = 2, VS = 2, VB = 3;
  localparam int unsigned HT = HD + HF + HS + HB;
  localparam int unsigned VT = VD + VF + VS + VB;
  localparam int unsigned FHT = 800, FVT = 525;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rgb_in = '0;
  logic [7:0]  rgb_in_f = 8'hD0;

  logic [10:0] x, y, x_f, y_f;
  logic        pixel_tick, video_on, frame_start, hsync, vsync;
  logic        pixel_tick_f, video_on_f, frame_start_f, hsync_f, vsync_f;
  logic [2:0]  red, green, red_f, green_f;
  logic [1:0]  blue, blue_f;

  always #5 clk = ~clk;

  vga_sync #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .reset(reset), .rgb_in(rgb_in), .x(x), .y(y),
    .pixel_tick(pixel_tick), .video_on(video_on), .frame_start(frame_start),
    .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue)
  );

  vga_sync dut_full (
    .clk(clk), .reset(reset), .rgb_in(rgb_in_f), .x(x_f), .y(y_f),
    .pixel_tick(pixel_tick_f), .video_on(video_on_f), .frame_start(frame_start_f),
    .hsync(hsync_f), .vsync(vsync_f), .red(red_f), .green(green_f), .blue(blue_f)
  );

  int unsigned errors = 0, checks = 0;
  int unsigned k = 0;          // clk edges since reset was last released
  int unsigned mode = 0;
  logic [7:0]  exp_rgb = '0;
  int unsigned fs_cnt = 0, hs_low = 0, vs_low = 0;

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at k=%0d: got %0d, expected %0d", tag, k, got, exp);
    end
  endtask

  function automatic bit in_win(input int unsigned v, input int unsigned lo, input int unsigned n);
    return (v >= lo) && (v < lo + n);
  endfunction

  task automatic check_small();
    int unsigned p, t, cx, cy, q, qx, qy, ehs, evs;
    p  = k / 2;
    t  = k % 2;
    cx = p % HT;
    cy = (p / HT) % VT;
    check_val("x", 32'(x), cx);
    check_val("y", 32'(y), cy);
    check_val("pixel_tick", 32'(pixel_tick), t);
    check_val("video_on", 32'(video_on), (cx < HD && cy < VD) ? 1 : 0);
    check_val("frame_start", 32'(frame_start), (t == 1 && cx == HT - 1 && cy == VT - 1) ? 1 : 0);
    ehs = 1;
    evs = 1;
    if (p > 0) begin
      q   = p - 1;
      qx  = q % HT;
      qy  = (q / HT) % VT;
      ehs = in_win(qx, HD + HF, HS) ? 0 : 1;
      evs = in_win(qy, VD + VF, VS) ? 0 : 1;
    end
    check_val("hsync", 32'(hsync), ehs);
    check_val("vsync", 32'(vsync), evs);
    check_val("red", 32'(red), 32'(exp_rgb[7:5]));
    check_val("green", 32'(green), 32'(exp_rgb[4:2]));
    check_val("blue", 32'(blue), 32'(exp_rgb[1:0]));
  endtask

  task automatic check_full();
    int unsigned p, t, cx, cy, q, qx, qy, ehs, evs, ec;
    p   = k / 2;
    t   = k % 2;
    cx  = p % FHT;
    cy  = (p / FHT) % FVT;
    ehs = 1;
    evs = 1;
    ec  = 0;
    if (p > 0) begin
      q   = p - 1;
      qx  = q % FHT;
      qy  = (q / FHT) % FVT;
      ehs = in_win(qx, 656, 96) ? 0 : 1;
      evs = in_win(qy, 490, 2) ? 0 : 1;
      ec  = (qx < 640 && qy < 480) ? 32'hD0 : 0;
    end
    check_val("full_x", 32'(x_f), cx);
    check_val("full_y", 32'(y_f), cy);
    check_val("full_tick", 32'(pixel_tick_f), t);
    check_val("full_video_on", 32'(video_on_f), (cx < 640 && cy < 480) ? 1 : 0);
    check_val("full_frame_start", 32'(frame_start_f), (t == 1 && cx == FHT - 1 && cy == FVT - 1) ? 1 : 0);
    check_val("full_hsync", 32'(hsync_f), ehs);
    check_val("full_vsync", 32'(vsync_f), evs);
    check_val("full_colour", 32'({red_f, green_f, blue_f}), ec);
  endtask

  task automatic step(input bit rst);
    int unsigned q;
    case (mode)
      0:       rgb_in = 8'($urandom);
      1:       rgb_in = 8'hD0;
      default: rgb_in = 8'((((k == 0) ? 0 : k - 1) / 2) % HT);  // graphic: x registered one clk late
    endcase
    reset = rst;
    @(posedge clk);
    if (rst) begin
      k       = 0;
      exp_rgb = '0;
    end else begin
      if (k % 2 == 1) begin
        q       = k / 2;
        exp_rgb = ((q % HT) < HD && ((q / HT) % VT) < VD) ? rgb_in : 8'h00;
      end
      k++;
    end
    #1;
    check_small();
    check_full();
    if (frame_start) fs_cnt++;
    if (!hsync) hs_low++;
    if (!vsync) vs_low++;
  endtask

  initial begin
    bit found;
    mode = 0;
    repeat (3) step(1'b1);

    fs_cnt = 0; hs_low = 0; vs_low = 0;
    repeat (2 * HT * VT) step(1'b0);
    check_val("frame_start_per_frame", fs_cnt, 1);
    check_val("hsync_low_clks_per_frame", hs_low, 2 * HS * VT);
    check_val("vsync_low_clks_per_frame", vs_low, 2 * HT * VS);

    mode = 1;
    repeat (2 * HT * VT) step(1'b0);
    mode = 2;
    repeat (2 * HT * VT) step(1'b0);

    mode  = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < 2 * HT * VT && !found; i++) begin
      step(1'b0);
      found = (((k / 2) % HT) == HD + HF + 2) && (((k / 2 / HT) % VT) == VD / 2);
    end
    check_val("midframe_position_reached", 32'(found), 1);
    step(1'b1);
    repeat (2 * HT * VT + 40) step(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
